// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state codes,
// opcodes, datapath select encodings and the bundled control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Shared with the ALU decoder, which resolves ALUOP_FUNCT from IR[5:0].
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALURES = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic     mem_req;
    logic     memwrite;
    logic     iord;
    logic     irwrite;
    logic     pcwrite;
    logic     branch;
    logic     branch_ne;
    logic     regdst;
    logic     memtoreg;
    logic     regwrite;
    logic     alusrca;
    alusrcb_e alusrcb;
    aluop_e   aluop;
    pcsrc_e   pcsrc;
    logic     instr_done;
    logic     illegal_op;
    logic     mem_err;
  } ctrl_t;

  // States that hold on the memory handshake and are guarded by the watchdog.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Memory request/ready handshake between the control FSM and the shared
// instruction/data memory.
interface mc_controller_if;
  logic mem_req;
  logic memwrite;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output memwrite, output iord, input mem_ready);
  modport slave  (input mem_req, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/mc_mem_watchdog.sv
// Wait-cycle counter for memory states; flags a timeout when TIMEOUT idle
// cycles have elapsed and the memory still is not ready.
module mc_mem_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic timeout
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a value on every path
  // (default first, then overrides) so no latch is inferred.
  always_comb begin
    timeout = in_mem_state && !mem_ready && (cnt_q == TO_W'(TIMEOUT));
    cnt_d   = cnt_q + TO_W'(1);
    // Held at zero outside memory states, so every memory state is entered with a clear count.
    if (!in_mem_state || mem_ready || timeout) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs from the same edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with Moore datapath controls and a watchdog on
// the memory handshake. Define MC_CTRL_BNE_EN to add the bne instruction.
module mc_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  mc_controller_if.master     mem,
  output logic                irwrite,
  output logic                pcwrite,
  output logic                branch,
  output logic                branch_ne,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          aluop,
  output logic [1:0]          pcsrc,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [3:0]          state_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_o;
  logic   timeout;

  mc_mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_mem_state (is_mem_state(state_q)),
    .mem_ready    (mem.mem_ready),
    .timeout      (timeout)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem.mem_ready;
        ctrl.pcwrite = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem.mem_ready;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNE: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch_ne  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Watchdog abort: no write strobe may escape with a dead memory.
    if (timeout) begin
      ctrl.memwrite   = 1'b0;
      ctrl.irwrite    = 1'b0;
      ctrl.pcwrite    = 1'b0;
      ctrl.instr_done = 1'b0;
      ctrl.mem_err    = 1'b1;
      state_d         = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced low the instant reset asserts, not at the next edge.
  always_comb ctrl_o = rst_n ? ctrl : '0;

  assign mem.mem_req  = ctrl_o.mem_req;
  assign mem.memwrite = ctrl_o.memwrite;
  assign mem.iord     = ctrl_o.iord;
  assign irwrite      = ctrl_o.irwrite;
  assign pcwrite      = ctrl_o.pcwrite;
  assign branch       = ctrl_o.branch;
  assign branch_ne    = ctrl_o.branch_ne;
  assign regdst       = ctrl_o.regdst;
  assign memtoreg     = ctrl_o.memtoreg;
  assign regwrite     = ctrl_o.regwrite;
  assign alusrca      = ctrl_o.alusrca;
  assign alusrcb      = ctrl_o.alusrcb;
  assign aluop        = ctrl_o.aluop;
  assign pcsrc        = ctrl_o.pcsrc;
  assign instr_done   = ctrl_o.instr_done;
  assign illegal_op   = ctrl_o.illegal_op;
  assign mem_err      = ctrl_o.mem_err;
  assign state_o      = state_q;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle MIPS control FSM; replaces the single-cycle main decoder.
- Sequences the shared-memory datapath (one memory for instructions and data, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and writeback states for R-type, lw, sw, beq, addi and j.
- Emits Moore-style datapath controls.
- Holds memory states on a req/ready handshake, with a watchdog timeout.

Parameters:
- TIMEOUT, 255: max cycles a memory state waits for mem_ready before abort; legal range 1..65535.
- TO_W, 16: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request valid
- memwrite  output  1  request is a write
- iord  output  1  0 = PC address, 1 = ALUOut address
- irwrite  output  1  load IR
- pcwrite  output  1  unconditional PC load
- branch  output  1  PC load if zero
- branch_ne  output  1  PC load if not zero; tied 0 without MC_CTRL_BNE_EN
- regdst  output  1  1 = rd, 0 = rt
- memtoreg  output  1  1 = data register, 0 = ALUOut
- regwrite  output  1  register file write
- alusrca  output  1  0 = PC, 1 = A
- alusrcb  output  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- mem_err  output  1  one-cycle pulse on watchdog abort
- state_o  output  4  current state, for debug

Behaviour:
- State encoding (4 bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12. Codes 13-15 are unused and return to FETCH on the next edge.
- Reset (rst_n=0, async):
  - state=FETCH; watchdog counter=0.
  - All 1-bit outputs are 0 and all multi-bit outputs are 0 while reset is held, including mem_req.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Go to DECODE on mem_ready; otherwise stay.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00.
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: pulse illegal_op and go to FETCH.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: lw -> MEMRD, sw -> MEMWR. Opcode is stable from IR.
- MEMRD: mem_req=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next: FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. On mem_ready: instr_done=1, go to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Next: FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next: FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Next: FETCH.
- Any output not listed for a state is 0.
- Latency with zero-wait memory (mem_ready=1 in the request cycle), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Watchdog:
  - Counter clears on entry to any memory state and on mem_ready.
  - Increments each cycle in FETCH/MEMRD/MEMWR while mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: pulse mem_err for that cycle, suppress all write strobes, go to FETCH, clear the counter.
  - mem_ready=1 in the same cycle as the timeout wins; it completes normally with no mem_err.
- mem_ready is ignored outside memory states.
- Reset asserted mid-instruction aborts immediately. No partial strobes are issued after rst_n falls.

Optional Feature:
- MC_CTRL_BNE_EN defined:
  - DECODE maps opcode 000101 -> BNE.
  - BNE state: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch_ne=1, instr_done=1. Next: FETCH.
- Undefined:
  - 000101 is illegal (illegal_op pulse); BNE code is unused; branch_ne is constant 0.

Decomposition:
- Shared package mc_pkg:
  - State enum/localparams.
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J).
  - alusrcb, pcsrc and aluop encodings.
  - The ALU decoder uses the same aluop encodings.
- One sub-module, mc_mem_watchdog: counter plus timeout compare; inputs in_mem_state, mem_ready; output timeout.
- Next-state logic and output logic live in mc_controller.

Test Plan:
- rst_n low mid-EXEC -> state_o=0 and all outputs 0 asynchronously; after release, mem_req=1 on the first cycle.
- lw with mem_ready tied 1 -> states 0,1,2,3,4; regwrite=1 with memtoreg=1 in cycle 5; instr_done exactly once.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles; instr_done on the 4th; total 7 cycles.
- R-type, addi, beq, j back-to-back with zero-wait memory -> 4+4+3+3=14 cycles, with per-state outputs exactly as listed.
- TIMEOUT=4 with mem_ready held 0 in FETCH -> mem_err pulse in the 5th FETCH cycle, irwrite never set, return to FETCH; mem_ready=1 on the timeout cycle -> no mem_err.
- Opcode 000101 -> with MC_CTRL_BNE_EN, BNE state with branch_ne=1, 3 cycles; without it, illegal_op pulse and FETCH after DECODE.
